// File: rtl/dot_accumulator.sv
// dot_accumulator: accumulates a commanded number of partial sums into one wide result with a sticky overflow flag
module dot_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overflow,
  input  logic                 out_ready,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t               state, state_n;
  logic [ACC_WIDTH-1:0] sum, sum_n;
  logic [LEN_WIDTH-1:0] remain, remain_n;
  logic                 ovf_n;
  logic [ACC_WIDTH:0]   add;
  logic                 accept;
  assign accept    = (state == ACCUM) && in_valid;
  // one extra bit captures the carry out of the accumulator MSB
  assign add       = {1'b0, sum} + (ACC_WIDTH+1)'(in_data);
  assign in_ready  = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign out_data  = sum;
  always_comb begin
    state_n  = state;
    sum_n    = sum;
    remain_n = remain;
    ovf_n    = overflow;
    if (state == IDLE && start) begin
      sum_n    = '0;
      ovf_n    = 1'b0;
      remain_n = len;
      state_n  = (len == '0) ? DONE : ACCUM;
    end else if (accept) begin
      sum_n    = add[ACC_WIDTH-1:0];
      ovf_n    = overflow | add[ACC_WIDTH];
      remain_n = remain - 1'b1;
      state_n  = (remain == LEN_WIDTH'(1)) ? DONE : ACCUM;
    end else if (state == DONE && out_ready) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sum      <= '0;
      remain   <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      sum      <= sum_n;
      remain   <= remain_n;
      overflow <= ovf_n;
    end
  end
endmodule
